// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment patterns,
// blank code and counter widths.
package disp_pkg;

  localparam int DEAD_W = 4;
  localparam int IDX_W  = 3;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    SEG_BLANK,   // codes 10..15 are not BCD and show nothing
    SEG_BLANK,
    SEG_BLANK,
    SEG_BLANK,
    SEG_BLANK,
    SEG_BLANK
  };

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD-to-7-segment decoder (active-low outputs).
module seg7_dec
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_PAT[bcd];

endmodule

// File: rtl/disp_scan.sv
// Multiplexed 7-segment display scanner with frame snapshot, dead time and blink.
// Optional macro LEADING_ZERO_BLANK_EN turns off leading-zero digits.
module disp_scan
  import disp_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int DEAD_CYC = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [4*NDIG-1:0] DIGITS,
  input  logic [NDIG-1:0]   DP,
  input  logic [NDIG-1:0]   BLINK_MASK,
  input  logic              BLINK,
  output logic [6:0]        SEG,
  output logic              DP_OUT,
  output logic [NDIG-1:0]   AN
);

  localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEAD_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);

  logic [IDX_W-1:0]  idx;
  logic [DEAD_W-1:0] dead;
  logic [4*NDIG-1:0] snap_digits;
  logic [NDIG-1:0]   snap_dp;
  logic [NDIG-1:0]   snap_mask;

  logic [3:0]        sel_digit;
  logic              sel_dp;
  logic              sel_mask;
  logic              sel_lz;
  logic [NDIG-1:0]   an_sel;
  logic [NDIG-1:0]   lz_blank;
  logic [6:0]        dec_seg;

  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [NDIG-1:0]   an_nxt;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic [NDIG-1:0]   an_q;

  // Scan state: the snapshot is only refreshed on the wrap, so a frame never tears.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx         <= '0;
      dead        <= DEAD_INIT;
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_mask   <= '0;
    end else if (ENABLE) begin
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      dead <= DEAD_INIT;
      if (idx == IDX_LAST) begin
        snap_digits <= DIGITS;
        snap_dp     <= DP;
        snap_mask   <= BLINK_MASK;
      end
    end else if (dead != '0) begin
      dead <= dead - 1'b1;
    end
  end

  always_comb begin
    sel_digit = '0;
    sel_dp    = 1'b0;
    sel_mask  = 1'b0;
    sel_lz    = 1'b0;
    an_sel    = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_digit = snap_digits[4*i +: 4];
        sel_dp    = snap_dp[i];
        sel_mask  = snap_mask[i];
        sel_lz    = lz_blank[i];
        an_sel[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is leading-zero while every digit
  // above it (and itself) is zero with no decimal point. Digit 0 always shows.
  always_comb begin
    logic lz_run;
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_run = lz_run && (snap_digits[4*i +: 4] == 4'd0) && !snap_dp[i];
      if (i > 0) lz_blank[i] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  seg7_dec u_dec (
    .bcd (sel_digit),
    .seg (dec_seg)
  );

  // BLINK is used live so the blink rate is independent of the frame rate.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    if (dead == '0) begin
      seg_nxt = dec_seg;
      dp_nxt  = ~sel_dp;
      if (!(sel_mask && BLINK) && !sel_lz) an_nxt = ~an_sel;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
    end
  end

  assign AN     = an_q;
  assign SEG    = seg_q;
  assign DP_OUT = dp_q;

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter NDIG, default 8: number of multiplexed digits; legal range 2..8.
REQ-002 Parameter DEAD_CYC, default 2: CLK cycles with all anodes off after each digit switch; legal range 1..15.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ENABLE  input  1  scan tick, one CLK wide; advances the digit index.
REQ-006 DIGITS  input  4*NDIG  packed BCD digits; digit 0 in bits [3:0], digit i in [4i+3:4i].
REQ-007 DP  input  NDIG  decimal-point request per digit.
REQ-008 BLINK_MASK  input  NDIG  digits subject to blinking.
REQ-009 BLINK  input  1  blink phase; 1 = blanking phase.
REQ-010 SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 DP_OUT  output  1  decimal point, active-low.
REQ-012 AN  output  NDIG  digit anodes, active-low, at most one bit low.

Function
REQ-013 Index IDX SHALL increment on each CLK with ENABLE=1; NDIG-1 wraps to 0.
REQ-014 On a CLK with ENABLE=1 and IDX=NDIG-1, the snapshot SHALL capture DIGITS, DP and BLINK_MASK; the display SHALL use the snapshot only, so there is no intra-frame tearing.
REQ-015 Dead counter DEAD SHALL load DEAD_CYC on every IDX advance, decrement by 1 per CLK while nonzero, and hold at 0.
REQ-016 While DEAD!=0, AN SHALL be all 1s and SEG/DP_OUT all 1s.
REQ-017 An ENABLE during a nonzero DEAD SHALL still advance IDX and reload DEAD.
REQ-018 When DEAD=0, AN bit IDX SHALL be 0, SEG SHALL be the decode of snapshot digit IDX, and DP_OUT SHALL be the inverse of snapshot DP[IDX].
REQ-019 SEG, DP_OUT and AN SHALL be registered with 1-cycle latency from IDX/DEAD/snapshot state.
REQ-020 BCD codes 0..9 SHALL decode to the standard pattern (0 = 7'b1000000, 8 = 7'b0000000); codes 10..15 SHALL decode to blank (7'b1111111).
REQ-021 If snapshot BLINK_MASK[IDX]=1 and BLINK=1, AN SHALL be all 1s for that digit; BLINK is sampled live, not snapshotted.
REQ-022 If ENABLE pulses are spaced at or below DEAD_CYC cycles, the display SHALL remain fully blank; this is legal, not an error.

Reset
REQ-023 RESET SHALL force IDX=0, DEAD=DEAD_CYC, snapshot all 0, AN all 1s, SEG 7'b1111111 and DP_OUT 1, immediately and asynchronously.
REQ-024 Reset asserted mid-frame SHALL discard the snapshot; the first post-reset frame SHALL show zeros until the first wrap capture.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, digit i (i>0) SHALL be blanked (AN off) when snapshot digits i..NDIG-1 are all 0 and DP[i..NDIG-1] are all 0.
REQ-026 Without LEADING_ZERO_BLANK_EN, all digits SHALL display, including leading zeros.

Structure
REQ-027 Shared package disp_pkg SHALL hold the 16-entry segment pattern constants, SEG_BLANK, and the DEAD counter width constant.
REQ-028 The BCD-to-segment decode SHALL be a sub-module named seg7_dec (combinational, 4 -> 7), instantiated once and driven by the IDX-selected digit.

Verification
REQ-029 Reset, then DIGITS=32'h20240101, ENABLE every 16 cycles -> after the first wrap, AN cycles 11111110..01111111 and digit 0 SEG=7'b1111001 ("1").
REQ-030 DEAD_CYC=2, single ENABLE -> AN=all 1s for exactly 2 cycles, then new anode low on the following cycle.
REQ-031 Change DIGITS mid-frame (IDX=3) -> displayed values change only after the IDX 7->0 wrap.
REQ-032 Digit 2 = 4'hC -> SEG=7'b1111111 while AN[2]=0.
REQ-033 BLINK_MASK=8'h03, BLINK toggling -> AN[1:0] stay high while BLINK=1; other digits are unaffected.
REQ-034 LEADING_ZERO_BLANK_EN defined, DIGITS=32'h00000059 -> only AN[0] and AN[1] ever go low; RESET pulsed mid-scan -> all outputs high asynchronously.
